// File: rtl/hdbn_pkg.sv
// Shared definitions for the HDBn line decoder: ternary symbol encodings,
// mark polarities and parameter legality helpers.
package hdbn_pkg;

    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b10,
        SYM_ILL  = 2'b11
    } sym_t;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_t;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 7;

    function automatic bit n_is_legal(input int unsigned n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

    function automatic logic is_mark(input sym_t s);
        return (s == SYM_POS) || (s == SYM_NEG);
    endfunction

    function automatic pol_t mark_pol(input sym_t s);
        return (s == SYM_POS) ? POL_POS : POL_NEG;
    endfunction

endpackage

// File: rtl/hdbn_err_counter.sv
// Saturating error counter; a clear on the same cycle as an increment wins.
module hdbn_err_counter #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] count
);

    logic [ERR_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hdbn_decoder.sv
// HDBn / AMI line decoder: removes B and V pulses of zero substitutions,
// flags code violations and emits one NRZ bit per symbol after N+2 beats.
module hdbn_decoder
    import hdbn_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [1:0]           sym_in,
    input  logic                 mode_ami,
    input  logic                 clr_err,
    output logic                 data_out,
    output logic                 data_valid,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (!n_is_legal(N)) begin : g_bad_n
        $fatal(1, "hdbn_decoder: N must be within 2..7");
    end

    localparam int unsigned CNT_W = $clog2(N + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N + 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sym_t             stage_q [0:N];
    sym_t             stage_d [0:N];
    pol_t             last_pol_q, last_pol_d;
    pol_t             last_v_pol_q, last_v_pol_d;
    logic             v_seen_q, v_seen_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             code_err_q, code_err_d;

    sym_t sym;
    sym_t new_sym;
    logic lead_zero;
    logic b_remove;
    logic beat_err;

    assign sym = sym_t'(sym_in);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        stage_d      = stage_q;
        last_pol_d   = last_pol_q;
        last_v_pol_d = last_v_pol_q;
        v_seen_d     = v_seen_q;
        run_d        = run_q;
        fill_d       = fill_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        code_err_d   = 1'b0;
        new_sym      = sym;
        b_remove     = 1'b0;
        beat_err     = 1'b0;

        // A V is only legal when the N-1 symbols before it are all zero.
        lead_zero = 1'b1;
        for (int unsigned i = 0; i < N - 1; i++) begin
            if (stage_q[i] != SYM_ZERO) lead_zero = 1'b0;
        end

        if (valid) begin
            if (sym == SYM_ILL) begin
                beat_err = 1'b1;
                new_sym  = SYM_ZERO;
            end else if (is_mark(sym)) begin
                last_pol_d = mark_pol(sym);
                if (mark_pol(sym) == last_pol_q) begin
                    if (mode_ami) begin
                        beat_err = 1'b1;
                    end else begin
                        new_sym = SYM_ZERO;
                        if (!lead_zero) beat_err = 1'b1;
                        else            b_remove = is_mark(stage_q[N-1]);
                        if (v_seen_q && (mark_pol(sym) == last_v_pol_q)) beat_err = 1'b1;
                        last_v_pol_d = mark_pol(sym);
                        v_seen_d     = 1'b1;
                    end
                end
            end

            // Line zero run; reports once when it first reaches N+1.
            if (sym == SYM_ZERO) begin
                if (run_q != CNT_FULL) run_d = run_q + CNT_ONE;
                if (!mode_ami && (run_q == RUN_LAST)) beat_err = 1'b1;
            end else begin
                run_d = '0;
            end

            stage_d[0] = new_sym;
            for (int unsigned i = 1; i < N; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            stage_d[N] = b_remove ? SYM_ZERO : stage_q[N-1];

            if (fill_q != CNT_FULL) fill_d = fill_q + CNT_ONE;
            data_valid_d = (fill_q == CNT_FULL);
            data_out_d   = is_mark(stage_q[N]);
            code_err_d   = beat_err;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst) begin
            // NOTE: the symbol pipeline is reset so stale symbols never leak into a new stream.
            for (int unsigned i = 0; i <= N; i++) begin
                stage_q[i] <= SYM_ZERO;
            end
            last_pol_q   <= POL_NEG;
            last_v_pol_q <= POL_NEG;
            v_seen_q     <= 1'b0;
            run_q        <= '0;
            fill_q       <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            last_pol_q   <= last_pol_d;
            last_v_pol_q <= last_v_pol_d;
            v_seen_q     <= v_seen_d;
            run_q        <= run_d;
            fill_q       <= fill_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            code_err_q   <= code_err_d;
        end
    end

    hdbn_err_counter #(
        .ERR_CNT_W(ERR_CNT_W)
    ) u_err_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (beat_err),
        .clr  (clr_err),
        .count(err_cnt)
    );

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign code_err   = code_err_q;

endmodule
